reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp.sv | 144 ++++++++++++++
 tb/tb_reg_file_mp.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with byte-strobed write, write-first read bypass,
// per-entry "written" tracking and an init/clear sweep that zeroes the array.
module reg_file_mp #(
    parameter int unsigned DWIDTH = 512,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned NRD    = 2,
    parameter int unsigned AWIDTH = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [AWIDTH-1:0]       wr_addr,
    input  logic [DWIDTH-1:0]       wr_data,
    input  logic [DWIDTH/8-1:0]     wr_strb,
    output logic                    wr_ready,
    input  logic                    clr,
    output logic                    busy,
    input  logic [NRD-1:0]          rd_en,
    input  logic [NRD*AWIDTH-1:0]   rd_addr,
    output logic [NRD*DWIDTH-1:0]   rd_data,
    output logic [NRD-1:0]          rd_valid,
    output logic [NRD-1:0]          rd_written
);

    localparam int unsigned       NB        = DWIDTH / 8;
    // One extra bit so addresses beyond DEPTH can be detected for non-power-of-two depths.
    localparam logic [AWIDTH:0]   DEPTH_EXT = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH-1:0] LAST      = AWIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {StInit, StIdle, StClear} state_e;

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] cnt_q, cnt_d;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  written_q;

    logic idle;
    logic sweep;
    logic wr_acc;

    assign busy     = (state_q != StIdle);
    assign wr_ready = !busy;
    assign idle     = rst_n && (state_q == StIdle);
    assign sweep    = rst_n && (state_q != StIdle);
    // A write in the same cycle as an accepted clear is dropped.
    assign wr_acc   = idle && wr_en && !clr && ({1'b0, wr_addr} < DEPTH_EXT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StInit, StClear: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            StIdle: begin
                if (clr) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StInit;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage is not reset; the sweep that follows reset zeroes it before any read is served.
    always_ff @(posedge clk) begin
        if (sweep) begin
            mem[cnt_q]       <= '0;
            written_q[cnt_q] <= 1'b0;
        end else if (wr_acc) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
            written_q[wr_addr] <= 1'b1;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AWIDTH-1:0] ra;
        logic              rd_acc;
        logic [DWIDTH-1:0] data_d, data_q;
        logic              wrt_d, wrt_q, valid_q;

        assign ra     = rd_addr[p*AWIDTH +: AWIDTH];
        assign rd_acc = idle && rd_en[p];

        always_comb begin
            data_d = '0;
            wrt_d  = 1'b0;
            if ({1'b0, ra} < DEPTH_EXT) begin
                data_d = mem[ra];
                wrt_d  = written_q[ra];
                // Write-first bypass: merge the strobed bytes of a concurrent write.
                if (wr_acc && (wr_addr == ra)) begin
                    for (int b = 0; b < NB; b++) begin
                        if (wr_strb[b]) begin
                            data_d[8*b +: 8] = wr_data[8*b +: 8];
                        end
                    end
                    wrt_d = 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                wrt_q   <= 1'b0;
            end else begin
                valid_q <= rd_acc;
                if (rd_acc) begin
                    data_q <= data_d;
                    wrt_q  <= wrt_d;
                end
            end
        end

        assign rd_data[p*DWIDTH +: DWIDTH] = data_q;
        assign rd_valid[p]                 = valid_q;
        assign rd_written[p]               = wrt_q;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed scenarios plus random traffic checked against an
// array-based reference model; a second DEPTH=12 instance covers out-of-range addresses.
module tb_reg_file_mp;

    localparam int DW  = 32;
    localparam int DEP = 16;
    localparam int NR  = 2;
    localparam int AW  = 4;
    localparam int NB  = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, wr_en, clr, wr_ready, busy;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic [NB-1:0]    wr_strb;
    logic [NR-1:0]    rd_en, rd_valid, rd_written;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;

    logic             d_rst_n, d_wr_en, d_clr, d_wr_ready, d_busy;
    logic [AW-1:0]    d_wr_addr;
    logic [DW-1:0]    d_wr_data;
    logic [NB-1:0]    d_wr_strb;
    logic [NR-1:0]    d_rd_en, d_rd_valid, d_rd_written;
    logic [NR*AW-1:0] d_rd_addr;
    logic [NR*DW-1:0] d_rd_data;

    reg_file_mp #(.DWIDTH(DW), .DEPTH(DEP), .NRD(NR)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_strb(wr_strb), .wr_ready(wr_ready), .clr(clr), .busy(busy), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_written(rd_written)
    );

    reg_file_mp #(.DWIDTH(DW), .DEPTH(12), .NRD(NR)) u_d12 (
        .clk(clk), .rst_n(d_rst_n), .wr_en(d_wr_en), .wr_addr(d_wr_addr),
        .wr_data(d_wr_data), .wr_strb(d_wr_strb), .wr_ready(d_wr_ready), .clr(d_clr),
        .busy(d_busy), .rd_en(d_rd_en), .rd_addr(d_rd_addr), .rd_data(d_rd_data),
        .rd_valid(d_rd_valid), .rd_written(d_rd_written)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model
    logic [DW-1:0] m_mem [DEP];
    bit            m_wr  [DEP];
    int            sweep_left;
    logic [DW-1:0] e_data  [NR];
    logic          e_wr    [NR];
    logic          e_valid [NR];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] nw,
                                            input logic [NB-1:0] strb);
        logic [DW-1:0] r = old;
        for (int b = 0; b < NB; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic model_zero();
        for (int i = 0; i < DEP; i++) begin
            m_mem[i] = '0;
            m_wr[i]  = 1'b0;
        end
    endtask

    // Advance the model by one edge from the current inputs, clock, then compare.
    task automatic tick();
        logic [AW-1:0] a;
        if (!rst_n) begin
            sweep_left = DEP;
            model_zero();
            for (int p = 0; p < NR; p++) begin
                e_valid[p] = 1'b0;
                e_data[p]  = '0;
                e_wr[p]    = 1'b0;
            end
        end else if (sweep_left > 0) begin
            for (int p = 0; p < NR; p++) e_valid[p] = 1'b0;
            sweep_left--;
        end else begin
            for (int p = 0; p < NR; p++) begin
                e_valid[p] = rd_en[p];
                if (rd_en[p]) begin
                    a          = rd_addr[p*AW +: AW];
                    e_data[p]  = m_mem[a];
                    e_wr[p]    = m_wr[a];
                    if (wr_en && !clr && wr_addr == a) begin
                        e_data[p] = merge(m_mem[a], wr_data, wr_strb);
                        e_wr[p]   = 1'b1;
                    end
                end
            end
            if (clr) begin
                sweep_left = DEP;
                model_zero();
            end else if (wr_en) begin
                m_mem[wr_addr] = merge(m_mem[wr_addr], wr_data, wr_strb);
                m_wr[wr_addr]  = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("busy", 64'(busy), 64'(sweep_left != 0));
        check("wr_ready", 64'(wr_ready), 64'(sweep_left == 0));
        for (int p = 0; p < NR; p++) begin
            check($sformatf("rd_valid[%0d]", p), 64'(rd_valid[p]), 64'(e_valid[p]));
            check($sformatf("rd_data[%0d]", p), 64'(rd_data[p*DW +: DW]), 64'(e_data[p]));
            check($sformatf("rd_written[%0d]", p), 64'(rd_written[p]), 64'(e_wr[p]));
        end
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; clr = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
        rd_en = '0; rd_addr = '0;
    endtask

    task automatic busy_len(input string tag);
        int cnt = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            tick();
            cnt++;
            wr_en = 1'b0;
        end
        check(tag, 64'(cnt), 64'(DEP));
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        d_rst_n = 1'b0; d_wr_en = 1'b0; d_clr = 1'b0; d_wr_addr = '0; d_wr_data = '0;
        d_wr_strb = '0; d_rd_en = '0; d_rd_addr = '0;

        // Reset and init sweep
        tick();
        tick();
        check("reset_busy", 64'(busy), 64'd1);
        check("reset_rd_valid", 64'(rd_valid), 64'd0);
        check("reset_rd_data", 64'(rd_data), 64'd0);
        rst_n   = 1'b1;
        d_rst_n = 1'b1;
        busy_len("init_len");

        // Every entry reads zero / unwritten after init
        for (int a = 0; a < DEP; a++) begin
            rd_en   = 2'b11;
            rd_addr = {AW'(a), AW'(DEP - 1 - a)};
            tick();
        end
        rd_en = '0;

        // Byte-strobed overwrite
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hAABBCCDD; wr_strb = 4'hF;
        tick();
        wr_data = 32'h11223344; wr_strb = 4'h5;
        tick();
        wr_en = 1'b0; rd_en = 2'b01; rd_addr = {4'd0, 4'd3};
        tick();
        check("strb_merge_data", 64'(rd_data[DW-1:0]), 64'h0000_0000_AA22_CC44);
        check("strb_merge_written", 64'(rd_written[0]), 64'd1);

        // Write-first bypass on both ports
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h12345678; wr_strb = 4'hF;
        rd_en = 2'b11; rd_addr = {4'd7, 4'd7};
        tick();
        idle_inputs();
        check("bypass_p0", 64'(rd_data[DW-1:0]), 64'h1234_5678);
        check("bypass_p1", 64'(rd_data[2*DW-1:DW]), 64'h1234_5678);
        check("bypass_written", 64'(rd_written), 64'd3);

        // Clear sweep drops a write issued during it
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF; wr_strb = 4'hF;
        tick();
        wr_en = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0; wr_en = 1'b1; wr_data = 32'h55555555;
        busy_len("clear_len");
        rd_en = 2'b10; rd_addr = {4'd5, 4'd0};
        tick();
        rd_en = '0;
        check("clear_addr5_data", 64'(rd_data[2*DW-1:DW]), 64'd0);
        check("clear_addr5_written", 64'(rd_written[1]), 64'd0);

        // Reset in the middle of a clear sweep restarts from entry 0
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (9) tick();
        check("mid_sweep_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        busy_len("restart_len");

        // Random traffic, with occasional clears and resets
        for (int i = 0; i < 600; i++) begin
            rst_n   = ($urandom_range(0, 199) != 0);
            clr     = ($urandom_range(0, 39) == 0);
            wr_en   = 1'($urandom);
            wr_addr = AW'($urandom);
            wr_data = $urandom;
            wr_strb = NB'($urandom);
            rd_en   = NR'($urandom);
            rd_addr = (NR*AW)'($urandom);
            if ($urandom_range(0, 3) == 0) rd_addr[AW-1:0] = wr_addr;
            tick();
        end
        rst_n = 1'b1;
        idle_inputs();
        for (int i = 0; i < 40 && busy; i++) tick();

        // DEPTH=12 instance: out-of-range write and read
        check("d12_idle", 64'(d_busy), 64'd0);
        d_wr_en = 1'b1; d_wr_addr = 4'd13; d_wr_data = 32'hFFFFFFFF; d_wr_strb = 4'hF;
        d_rd_en = 2'b11; d_rd_addr = {4'd13, 4'd13};
        tick();
        d_wr_en = 1'b0;
        check("d12_oor_valid", 64'(d_rd_valid), 64'd3);
        check("d12_oor_data", 64'(d_rd_data), 64'd0);
        check("d12_oor_written", 64'(d_rd_written), 64'd0);
        for (int a = 0; a < 6; a++) begin
            d_rd_addr = {AW'(a + 6), AW'(a)};
            tick();
            check($sformatf("d12_entry_%0d_%0d_valid", a, a + 6), 64'(d_rd_valid), 64'd3);
            check($sformatf("d12_entry_%0d_%0d_data", a, a + 6), 64'(d_rd_data), 64'd0);
            check($sformatf("d12_entry_%0d_%0d_written", a, a + 6),
                  64'(d_rd_written), 64'd0);
        end
        d_rd_en = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
